// File: rtl/mdu_iter_div_pkg.sv
// Shared M-extension definitions for the iterative divider: op flag positions,
// FSM states, operand width and most-negative constants.
package mdu_iter_div_pkg;

    localparam int XLEN = 64;

    localparam int OP_SIGNED = 0;
    localparam int OP_REM    = 1;
    localparam int OP_WORD   = 2;
    localparam int OP_W      = 3;

    localparam logic [31:0] MIN_NEG32 = 32'h8000_0000;
    localparam logic [63:0] MIN_NEG64 = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module mdu_div_step
    import mdu_iter_div_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [W:0] rem_sh;
    logic [W:0] diff;

    assign rem_sh = {rem_i, quo_i[W-1]};
    assign diff   = rem_sh - {1'b0, div_i};
    assign rem_o  = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
    assign quo_o  = {quo_i[W-2:0], ~diff[W]};

endmodule

// File: rtl/mdu_iter_div.sv
// Multi-cycle radix-2 restoring divider for the RV64M divide group, with
// divide-by-zero and signed-overflow results resolved at accept.
module mdu_iter_div
    import mdu_iter_div_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic            in_rem,
    input  logic            in_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    div_state_e      state_q, state_d;
    logic [OP_W-1:0] op_q, op_d, op_in;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, fast_res;
    logic [XLEN-1:0] q_fin, r_fin, fix_res, step_rem, step_quo;
    logic            div0, ovf;

    mdu_div_step #(.W(XLEN)) u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .div_i(dvs_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    always_comb begin
        op_in            = '0;
        op_in[OP_SIGNED] = in_signed;
        op_in[OP_REM]    = in_rem;
        op_in[OP_WORD]   = in_word;

        if (in_word) begin
            a_ext = in_signed ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]};
            b_ext = in_signed ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]};
        end else begin
            a_ext = src1;
            b_ext = src2;
        end
        a_abs = (in_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
        b_abs = (in_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;

        div0 = (b_ext == '0);
        ovf  = in_signed && (b_ext == '1)
               && (a_ext == (in_word ? sext32(MIN_NEG32) : MIN_NEG64));

        fast_res = in_rem ? (div0 ? a_ext : '0) : (div0 ? '1 : a_ext);
        if (in_word) fast_res = sext32(fast_res[31:0]);

        q_fin   = (op_q[OP_SIGNED] && (sa_q ^ sb_q)) ? -quo_q : quo_q;
        r_fin   = (op_q[OP_SIGNED] && sa_q) ? -rem_q : rem_q;
        fix_res = op_q[OP_REM] ? r_fin : q_fin;
        if (op_q[OP_WORD]) fix_res = sext32(fix_res[31:0]);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_d       = op_in;
                    sa_d       = a_ext[XLEN-1];
                    sb_d       = b_ext[XLEN-1];
                    in_ready_d = 1'b0;
                    if (div0 || ovf) begin
                        out_data_d  = fast_res;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        // Word dividends sit in the top half so 32 shifts consume them.
                        rem_d   = '0;
                        quo_d   = in_word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                        dvs_d   = b_abs;
                        cnt_d   = in_word ? 6'd31 : 6'd63;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd0) state_d = S_FIX;
                end
                S_FIX: begin
                    out_data_d  = fix_res;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mdu_iter_div.sv
// Directed bench for mdu_iter_div: arithmetic, corner results, latency,
// back-pressure, flush and mid-operation reset.
module tb_mdu_iter_div;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic        in_rem = 1'b0;
    logic        in_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    mdu_iter_div dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_rem(in_rem), .in_word(in_word),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic s, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        int t = 0;
        @(negedge clock);
        in_signed = s; in_rem = r; in_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Latency counted so the first cycle after the accept edge is cycle 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 200) chk("result_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic s, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(s, r, w, a, b);
        wait_valid(lat);
        chk(tag, out_data, exp);
        if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        take();
    endtask

    initial begin
        int lat;
        int vcnt;

        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("divu_100_7", 0, 0, 0, 64'd100, 64'd7, 64'd14, 66);
        run_op("remu_100_7", 0, 1, 0, 64'd100, 64'd7, 64'd2, 66);
        run_op("div_m7_2",   1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_m7_2",   1, 1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("div_100_m7", 1, 0, 0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 0);
        run_op("rem_100_m7", 1, 1, 0, 64'd100, -64'sd7, 64'd2, 0);
        run_op("divu_big",   0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 0);
        run_op("remu_big",   0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 0);
        run_op("div_ovf",    1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",    1, 1, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw_ovf",   1, 0, 1, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("remuw_div0", 0, 1, 1, 64'd5, 64'd0, 64'd5, 1);
        run_op("divu_div0",  0, 0, 0, 64'h1234_5678, 64'd0, '1, 1);
        run_op("divuw_100_7", 0, 0, 1, 64'd100, 64'd7, 64'd14, 34);
        run_op("divw_m100_7", 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34);
        run_op("remw_m100_7", 1, 1, 1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("divuw_sext", 0, 0, 1, 64'hFFFF_FFFF, 64'd1, '1, 34);

        // Back-pressure with a competing request held on the input.
        issue(0, 0, 0, 64'd50, 64'd5);
        wait_valid(lat);
        in_signed = 0; in_rem = 0; in_word = 0; src1 = 64'd9; src2 = 64'd3; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_data", out_data, 64'd10);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        chk("bp_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("bp_accepted", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("bp_next_res", out_data, 64'd3);
        take();

        // Flush mid-CALC.
        issue(0, 0, 0, 64'd1000, 64'd3);
        repeat (20) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        vcnt = 0;
        repeat (80) begin
            @(negedge clock);
            if (out_valid) vcnt++;
        end
        chk("flush_no_result", 64'(vcnt), 64'd0);

        // A request alongside flush is dropped.
        in_signed = 0; in_rem = 0; in_word = 0; src1 = 64'd8; src2 = 64'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_req_ready", 64'(in_ready), 64'd1);
        chk("flush_req_valid", 64'(out_valid), 64'd0);
        run_op("divu_9_3", 0, 0, 0, 64'd9, 64'd3, 64'd3, 66);

        // Reset pulse mid-CALC; out_data holds 3 beforehand.
        issue(0, 0, 0, 64'd1000, 64'd3);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("remu_1000_3", 0, 1, 0, 64'd1000, 64'd3, 64'd1, 66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
